// File: rtl/alu_sequencer.sv
// +----------------------------------------------------------------------+
// | alu_sequencer: command FIFO and load/run/capture sequencer for alu16 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module alu_sequencer #(
  parameter int DEPTH       = 4,
  parameter int LOAD_CYCLES = 2,
  parameter int RUN_CYCLES  = 17
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [2:0]  cmd_op_i,
  input  logic [15:0] cmd_a_i,
  input  logic [15:0] cmd_b_i,
  output logic        alu_on_o,
  output logic [2:0]  alu_op_o,
  output logic [15:0] alu_ina_o,
  output logic [15:0] alu_inb_o,
  input  logic [16:0] alu_out_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [16:0] res_data_o,
  output logic [2:0]  res_op_o,
  output logic        busy_o
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CMAX = (LOAD_CYCLES > RUN_CYCLES) ? LOAD_CYCLES : RUN_CYCLES;
  localparam int CW   = $clog2(CMAX) + 1;

  localparam logic [CW-1:0] LOAD_LAST = CW'(LOAD_CYCLES - 1);
  localparam logic [CW-1:0] RUN_LAST  = CW'(RUN_CYCLES - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } state_e;

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
  } cmd_t;

  cmd_t mem_q [DEPTH];

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic [15:0]   ina_q, ina_d;
  logic [15:0]   inb_q, inb_d;
  logic [16:0]   res_data_q, res_data_d;
  logic [2:0]    res_op_q, res_op_d;

  logic full;
  logic empty;
  logic push;
  logic pop;
  cmd_t head;

  // Full blocks a push even when the sequencer pops in the same cycle.
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign push  = cmd_valid_i & ~full;
  assign pop   = (state_q == IDLE) & ~empty;
  assign head  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{op: cmd_op_i, a: cmd_a_i, b: cmd_b_i};
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    ina_d      = ina_q;
    inb_d      = inb_q;
    res_data_d = res_data_q;
    res_op_d   = res_op_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (pop) begin
          op_d    = head.op;
          ina_d   = head.a;
          inb_d   = head.b;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (cnt_q == LOAD_LAST) begin
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        // alu_out is only trusted on the edge that closes the final RUN cycle.
        if (cnt_q == RUN_LAST) begin
          res_data_d = alu_out_i;
          res_op_d   = op_q;
          state_d    = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (res_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cnt_q      <= '0;
      op_q       <= '0;
      ina_q      <= '0;
      inb_q      <= '0;
      res_data_q <= '0;
      res_op_q   <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      ina_q      <= ina_d;
      inb_q      <= inb_d;
      res_data_q <= res_data_d;
      res_op_q   <= res_op_d;
    end
  end

  assign cmd_ready_o = ~full;
  assign alu_on_o    = (state_q == LOAD);
  assign alu_op_o    = op_q;
  assign alu_ina_o   = ina_q;
  assign alu_inb_o   = inb_q;
  assign res_valid_o = (state_q == HOLD);
  assign res_data_o  = res_data_q;
  assign res_op_o    = res_op_q;
  assign busy_o      = (state_q != IDLE) | ~empty;

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// +----------------------------------------------------------------------+
// | tb_alu_sequencer: directed bench for alu_sequencer with alu16 stand-in |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_alu_sequencer;

  localparam int DEPTH       = 4;
  localparam int LOAD_CYCLES = 2;
  localparam int RUN_CYCLES  = 17;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic        alu_on;
  logic [2:0]  alu_op;
  logic [15:0] alu_ina;
  logic [15:0] alu_inb;
  logic [16:0] alu_out;
  logic        res_valid;
  logic        res_ready;
  logic [16:0] res_data;
  logic [2:0]  res_op;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc_n    = 0;
  int run_cnt  = 31;

  alu_sequencer #(
    .DEPTH       (DEPTH),
    .LOAD_CYCLES (LOAD_CYCLES),
    .RUN_CYCLES  (RUN_CYCLES)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_a_i     (cmd_a),
    .cmd_b_i     (cmd_b),
    .alu_on_o    (alu_on),
    .alu_op_o    (alu_op),
    .alu_ina_o   (alu_ina),
    .alu_inb_o   (alu_inb),
    .alu_out_i   (alu_out),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_data_o  (res_data),
    .res_op_o    (res_op),
    .busy_o      (busy)
  );

  function automatic logic [16:0] alu_model(input logic [2:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      default: return {1'b0, a};
    endcase
  endfunction

  // The stand-in ALU shows junk until the serial run has had time to finish.
  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (alu_on) run_cnt <= 0;
    else if (run_cnt < 31) run_cnt <= run_cnt + 1;
  end

  assign alu_out = (run_cnt >= RUN_CYCLES - 1) ? alu_model(alu_op, alu_ina, alu_inb) : 17'h15A5A;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b);
    cmd_valid = v;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
  endtask

  task automatic wait_res(input int maxc);
    int k = 0;
    while (res_valid !== 1'b1 && k < maxc) begin
      cyc();
      k++;
    end
    chk("res_valid_wait", 32'(res_valid), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_alu_on"},    32'(alu_on),    32'd0);
    chk({tag, "_alu_op"},    32'(alu_op),    32'd0);
    chk({tag, "_alu_ina"},   32'(alu_ina),   32'd0);
    chk({tag, "_alu_inb"},   32'(alu_inb),   32'd0);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_res_data"},  32'(res_data),  32'd0);
    chk({tag, "_res_op"},    32'(res_op),    32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  logic [2:0]  b_op  [0:4] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
  logic [15:0] b_a   [0:4] = '{16'h0010, 16'hF0F0, 16'h1200, 16'hFFFF, 16'hFFFF};
  logic [15:0] b_b   [0:4] = '{16'h0001, 16'h3C3C, 16'h0034, 16'h00FF, 16'h0001};
  logic [16:0] b_exp [0:4] = '{17'h0000F, 17'h03030, 17'h01234, 17'h0FF00, 17'h10000};

  logic [2:0]  f_op  [0:4] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
  logic [15:0] f_a   [0:4] = '{16'h1111, 16'h0001, 16'hABCD, 16'h8000, 16'hAAAA};
  logic [15:0] f_b   [0:4] = '{16'h2222, 16'h0002, 16'h0FF0, 16'h0001, 16'h5555};
  logic [16:0] f_exp [0:4] = '{17'h03333, 17'h1FFFF, 17'h00BC0, 17'h08001, 17'h0FFFF};

  initial begin
    int t_prev;
    logic seen;

    rst_n     = 1'b0;
    res_ready = 1'b0;
    drive(1'b0, 3'd0, 16'h0, 16'h0);
    repeat (3) cyc();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    cyc();

    // Single add command, latency and operand stability.
    res_ready = 1'b1;
    drive(1'b1, 3'd0, 16'h7002, 16'h0003);
    chk("single_cmd_ready_T", 32'(cmd_ready), 32'd1);
    cyc();
    drive(1'b0, 3'd0, 16'h0, 16'h0);
    chk("single_busy_T1", 32'(busy), 32'd1);
    chk("single_alu_on_T1", 32'(alu_on), 32'd0);
    cyc();
    chk("single_alu_on_T2", 32'(alu_on), 32'd1);
    chk("single_ina_T2", 32'(alu_ina), 32'h7002);
    chk("single_inb_T2", 32'(alu_inb), 32'h0003);
    chk("single_op_T2", 32'(alu_op), 32'd0);
    cyc();
    chk("single_alu_on_T3", 32'(alu_on), 32'd1);
    cyc();
    chk("single_alu_on_T4", 32'(alu_on), 32'd0);
    for (int i = 5; i <= 20; i++) begin
      cyc();
      chk("single_run_alu_on", 32'(alu_on), 32'd0);
      chk("single_run_ina", 32'(alu_ina), 32'h7002);
      chk("single_run_inb", 32'(alu_inb), 32'h0003);
      chk("single_run_res_valid", 32'(res_valid), 32'd0);
    end
    chk("single_res_data_T20", 32'(res_data), 32'd0);
    cyc();
    chk("single_res_valid_T21", 32'(res_valid), 32'd1);
    chk("single_res_data_T21", 32'(res_data), 32'h07005);
    chk("single_res_op_T21", 32'(res_op), 32'd0);
    chk("single_busy_T21", 32'(busy), 32'd1);
    cyc();
    chk("single_res_valid_T22", 32'(res_valid), 32'd0);
    cyc();
    chk("single_busy_T23", 32'(busy), 32'd0);

    // Back-to-back: five consecutive pushes, results 21 cycles apart.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, b_op[i], b_a[i], b_b[i]);
      chk("b2b_cmd_ready", 32'(cmd_ready), 32'd1);
      cyc();
    end
    drive(1'b0, 3'd0, 16'h0, 16'h0);
    t_prev = 0;
    for (int i = 0; i < 5; i++) begin
      wait_res(40);
      if (i > 0) chk("b2b_gap", 32'(cyc_n - t_prev), 32'd21);
      t_prev = cyc_n;
      chk("b2b_res_data", 32'(res_data), 32'(b_exp[i]));
      chk("b2b_res_op", 32'(res_op), 32'(b_op[i]));
      cyc();
    end
    chk("b2b_busy_after", 32'(busy), 32'd0);

    // Full FIFO with backpressure; a push held while full must be dropped.
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, f_op[i], f_a[i], f_b[i]);
      chk("full_cmd_ready_accept", 32'(cmd_ready), 32'd1);
      cyc();
    end
    drive(1'b1, 3'd0, 16'h0BAD, 16'h0001);
    chk("full_cmd_ready_full", 32'(cmd_ready), 32'd0);
    wait_res(40);
    for (int i = 0; i < 10; i++) begin
      chk("bp_res_valid", 32'(res_valid), 32'd1);
      chk("bp_res_data", 32'(res_data), 32'(f_exp[0]));
      chk("bp_res_op", 32'(res_op), 32'(f_op[0]));
      chk("bp_alu_on", 32'(alu_on), 32'd0);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      cyc();
    end
    res_ready = 1'b1;
    chk("bp_res_valid_hs", 32'(res_valid), 32'd1);
    cyc();
    chk("bp_pop_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("bp_pop_alu_on", 32'(alu_on), 32'd0);
    chk("bp_pop_res_valid", 32'(res_valid), 32'd0);
    cyc();
    drive(1'b0, 3'd0, 16'h0, 16'h0);
    chk("bp_next_alu_on", 32'(alu_on), 32'd1);
    chk("bp_next_ina", 32'(alu_ina), 32'(f_a[1]));
    chk("bp_next_op", 32'(alu_op), 32'(f_op[1]));
    chk("bp_next_cmd_ready", 32'(cmd_ready), 32'd1);
    for (int i = 1; i < 5; i++) begin
      wait_res(40);
      chk("full_res_data", 32'(res_data), 32'(f_exp[i]));
      chk("full_res_op", 32'(res_op), 32'(f_op[i]));
      cyc();
    end
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (res_valid === 1'b1) seen = 1'b1;
      cyc();
    end
    chk("full_no_extra_result", 32'(seen), 32'd0);
    chk("full_busy_drained", 32'(busy), 32'd0);

    // Reset in the middle of RUN with two commands queued.
    drive(1'b1, 3'd5, 16'h1357, 16'h2468);
    cyc();
    drive(1'b1, 3'd2, 16'h00FF, 16'h0F0F);
    cyc();
    drive(1'b1, 3'd3, 16'h4000, 16'h0004);
    cyc();
    drive(1'b0, 3'd0, 16'h0, 16'h0);
    repeat (7) cyc();
    chk("rst_pre_busy", 32'(busy), 32'd1);
    chk("rst_pre_ina", 32'(alu_ina), 32'h1357);
    chk("rst_pre_alu_on", 32'(alu_on), 32'd0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_async");
    cyc();
    cyc();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (res_valid === 1'b1) seen = 1'b1;
      cyc();
    end
    chk("rst_no_result", 32'(seen), 32'd0);
    chk("rst_busy_after", 32'(busy), 32'd0);
    chk("rst_cmd_ready_after", 32'(cmd_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
